fp_div_sched: RTL

- Round-robin scheduler that shares one fp_div instance among NREQ requesters.
- Captures one request at a time and drives the divider operands, rounding mode and act.
- Waits for the divider's done, with a timeout watchdog.
- Returns the result and exception flags to the granted requester through a valid/ready response port.
- Sits between the core-side requesters and the divider; contains no arithmetic of its own.

---
 rtl/fp_div_sched_if.sv | 59 +++++
 rtl/fp_div_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fp_div_sched_if.sv
// fp_div_sched_if: bundles every signal between the divider scheduler and
// its environment (requesters, the shared fp_div, the response consumer).
//   master : the environment side; drives requests, divider results and
//            rsp_ready, and observes grants, divider operands and responses.
//   slave  : the scheduler side; the mirror image of master.
// Signal groups:
//   req/req_in1/req_in2/req_rm/gnt          requester arbitration port
//   div_act/div_in1/div_in2/div_round_m     operands driven to the divider
//   div_out/div_ov/div_un/div_inv/div_zero/
//   div_inexact/div_done                    results from the divider
//   rsp_valid/rsp_ready/rsp_id/rsp_out/
//   rsp_flags                               response port
//   busy                                    scheduler not idle
interface fp_div_sched_if #(
  parameter int W    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_in1;
  logic [NREQ*W-1:0] req_in2;
  logic [NREQ*3-1:0] req_rm;
  logic [NREQ-1:0]   gnt;

  logic              div_act;
  logic [W-1:0]      div_in1;
  logic [W-1:0]      div_in2;
  logic [2:0]        div_round_m;
  logic [W-1:0]      div_out;
  logic              div_ov;
  logic              div_un;
  logic              div_inv;
  logic              div_zero;
  logic              div_inexact;
  logic              div_done;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_out;
  logic [5:0]        rsp_flags;
  logic              busy;

  modport master (
    output req, req_in1, req_in2, req_rm,
    output div_out, div_ov, div_un, div_inv, div_zero, div_inexact, div_done,
    output rsp_ready,
    input  gnt, div_act, div_in1, div_in2, div_round_m,
    input  rsp_valid, rsp_id, rsp_out, rsp_flags, busy
  );

  modport slave (
    input  req, req_in1, req_in2, req_rm,
    input  div_out, div_ov, div_un, div_inv, div_zero, div_inexact, div_done,
    input  rsp_ready,
    output gnt, div_act, div_in1, div_in2, div_round_m,
    output rsp_valid, rsp_id, rsp_out, rsp_flags, busy
  );
endinterface

// File: rtl/fp_div_sched.sv
// fp_div_sched: round-robin scheduler sharing a single fp_div among NREQ
// requesters. One operation is in flight at a time: a request is granted and
// its operands captured, the divider is started with a one-cycle act pulse,
// its done is awaited (with a settle window and a timeout watchdog), and the
// result plus flags are returned over a valid/ready response port.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - fp_div_sched_if.slave carrying request, divider and response signals
module fp_div_sched #(
  parameter int W      = 32,
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 2,
  parameter int TMO    = 64,
  parameter int TW     = 7
) (
  input logic           clk,
  input logic           rst,
  fp_div_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    cur_id_q, cur_id_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              div_act_q, div_act_d;
  logic [W-1:0]      div_in1_q, div_in1_d;
  logic [W-1:0]      div_in2_q, div_in2_d;
  logic [2:0]        div_round_m_q, div_round_m_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [W-1:0]      rsp_out_q, rsp_out_d;
  logic [5:0]        rsp_flags_q, rsp_flags_d;

  logic              found;
  logic [IDW-1:0]    win_id;
  logic [NREQ-1:0]   req_sh;
  logic [NREQ*W-1:0] in1_sh;
  logic [NREQ*W-1:0] in2_sh;
  logic [NREQ*3-1:0] rm_sh;

  // Round-robin search starting just after the last winner. Shifts are used
  // instead of variable bit-selects so that the index width never matters.
  always_comb begin
    int idx;
    found  = 1'b0;
    win_id = '0;
    req_sh = '0;
    idx    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      req_sh = bus.req >> idx;
      if (!found && req_sh[0]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end
    in1_sh = bus.req_in1 >> (int'(win_id) * W);
    in2_sh = bus.req_in2 >> (int'(win_id) * W);
    rm_sh  = bus.req_rm  >> (int'(win_id) * 3);
  end

  // Next-state and output logic. Every register holds by default; gnt and
  // div_act are pulses and default low. div_act is registered out of ISSUE,
  // so it appears in the first WAIT cycle, where the counter is zero.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cur_id_d      = cur_id_q;
    gnt_d         = '0;
    div_act_d     = 1'b0;
    div_in1_d     = div_in1_q;
    div_in2_d     = div_in2_q;
    div_round_m_d = div_round_m_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_out_d     = rsp_out_q;
    rsp_flags_d   = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d         = NREQ'(1) << win_id;
          div_in1_d     = in1_sh[W-1:0];
          div_in2_d     = in2_sh[W-1:0];
          div_round_m_d = rm_sh[2:0];
          cur_id_d      = win_id;
          rr_ptr_d      = win_id;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        div_act_d = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + TW'(1);
        // A done inside the settle window may be left over from the previous
        // operation; a qualified done takes priority over the watchdog.
        if (bus.div_done && (cnt_q >= TW'(SETTLE))) begin
          rsp_out_d   = bus.div_out;
          rsp_flags_d = {1'b0, bus.div_ov, bus.div_un, bus.div_inv,
                         bus.div_zero, bus.div_inexact};
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q >= TW'(TMO)) begin
          rsp_out_d   = W'(32'h7FC0_0000);
          rsp_flags_d = 6'b100100;
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= IDW'(NREQ - 1);
      cur_id_q      <= '0;
      gnt_q         <= '0;
      div_act_q     <= 1'b0;
      div_in1_q     <= '0;
      div_in2_q     <= '0;
      div_round_m_q <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_out_q     <= '0;
      rsp_flags_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_id_q      <= cur_id_d;
      gnt_q         <= gnt_d;
      div_act_q     <= div_act_d;
      div_in1_q     <= div_in1_d;
      div_in2_q     <= div_in2_d;
      div_round_m_q <= div_round_m_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_out_q     <= rsp_out_d;
      rsp_flags_q   <= rsp_flags_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.div_act     = div_act_q;
  assign bus.div_in1     = div_in1_q;
  assign bus.div_in2     = div_in2_q;
  assign bus.div_round_m = div_round_m_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_out     = rsp_out_q;
  assign bus.rsp_flags   = rsp_flags_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
